trap_sequencer: RTL

- Sequences trap entry and exception return around the PCR file.
- Accepts synchronous exceptions from the pipeline, the PCR file's interrupt line, and eret.
- Flushes the pipeline, issues a one-cycle commit that updates epc/cause/badvaddr/status, then redirects fetch to evec (trap) or epc (eret).
- Sits between the decode/execute stages, the control processor and the fetch unit.

---
 rtl/trap_sequencer_if.sv | 22 ++
 rtl/trap_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/trap_sequencer_if.sv
// trap_sequencer_if: fetch redirect handshake between the trap sequencer
// (master) and the fetch unit (slave).
//   redirect_valid : redirect request, held until accepted
//   redirect_pc    : redirect target, stable while redirect_valid is high
//   redirect_ready : fetch accepts the redirect this cycle
interface trap_sequencer_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  modport master (
    output redirect_valid,
    output redirect_pc,
    input  redirect_ready
  );

  modport slave (
    input  redirect_valid,
    input  redirect_pc,
    output redirect_ready
  );
endinterface

// File: rtl/trap_sequencer.sv
// trap_sequencer: sequences trap entry and exception return around the PCR
// file. Samples synchronous exceptions, the PCR interrupt line and eret while
// idle, flushes the pipeline for DRAIN_CYCLES, issues a one-cycle commit to
// the PCR file, then redirects fetch to evec (trap) or epc (eret).
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   stall               pipeline/memory stall; sequencer holds state
//   exc_*               synchronous exception (valid, cause, pc, badvaddr)
//   interrupt, irq_id, int_pc   interrupt request from the PCR file
//   eret                eret instruction in execute
//   et, evec, epc       PCR file status ET bit, trap vector, current epc
//   flush, busy         kill in-flight instructions / sequencer not idle
//   trap_commit, trap_epc, trap_cause, badvaddr_we, trap_badvaddr
//                       trap commit pulse and the values to write
//   eret_commit         eret commit pulse
//   redir               fetch redirect handshake (trap_sequencer_if.master)
//   halted              double fault lock
//
// Build option: define TRAP_SEQ_DOUBLE_FAULT_EN to lock the sequencer in
// HALT on an exception taken with ET=0; otherwise halted is constant 0.
module trap_sequencer #(
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   exc_valid,
  input  logic [4:0]             exc_cause,
  input  logic [31:0]            exc_pc,
  input  logic [31:0]            exc_badvaddr,
  input  logic                   exc_badvaddr_valid,
  input  logic                   interrupt,
  input  logic [2:0]             irq_id,
  input  logic [31:0]            int_pc,
  input  logic                   eret,
  input  logic                   et,
  input  logic [31:0]            evec,
  input  logic [31:0]            epc,
  output logic                   flush,
  output logic                   busy,
  output logic                   trap_commit,
  output logic [31:0]            trap_epc,
  output logic [31:0]            trap_cause,
  output logic                   badvaddr_we,
  output logic [31:0]            trap_badvaddr,
  output logic                   eret_commit,
  trap_sequencer_if.master       redir,
  output logic                   halted
);

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    COMMIT,
    REDIRECT,
    HALT
  } state_t;

  localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYCLES);

  state_t      state;
  logic [2:0]  drain_cnt;
  logic        is_eret_q;
  logic        commit_q;
  logic        flush_q;
  logic        busy_q;
  logic        bv_we_q;
  logic        halted_q;
  logic        rv_q;
  logic [31:0] rpc_q;
  logic [31:0] epc_q;
  logic [31:0] cause_q;
  logic [31:0] bv_q;

  logic irq_take;
  logic any_event;
  logic double_fault;

  assign irq_take  = interrupt & et;
  assign any_event = exc_valid | irq_take | eret;

`ifdef TRAP_SEQ_DOUBLE_FAULT_EN
  assign double_fault = exc_valid & ~et;
`else
  assign double_fault = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      drain_cnt <= '0;
      is_eret_q <= 1'b0;
      commit_q  <= 1'b0;
      flush_q   <= 1'b0;
      busy_q    <= 1'b0;
      bv_we_q   <= 1'b0;
      halted_q  <= 1'b0;
      rv_q      <= 1'b0;
      rpc_q     <= '0;
      epc_q     <= '0;
      cause_q   <= '0;
      bv_q      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!stall && any_event) begin
            flush_q <= 1'b1;
            busy_q  <= 1'b1;
            if (double_fault) begin
              state    <= HALT;
              halted_q <= 1'b1;
            end else begin
              if (exc_valid) begin
                is_eret_q <= 1'b0;
                epc_q     <= exc_pc;
                cause_q   <= {27'b0, exc_cause};
                bv_q      <= exc_badvaddr;
                bv_we_q   <= exc_badvaddr_valid;
              end else if (irq_take) begin
                is_eret_q <= 1'b0;
                epc_q     <= int_pc;
                cause_q   <= {1'b1, 28'b0, irq_id};
                bv_q      <= '0;
                bv_we_q   <= 1'b0;
              end else begin
                is_eret_q <= 1'b1;
                bv_we_q   <= 1'b0;
              end
              if (DRAIN_CYCLES == 0) begin
                state    <= COMMIT;
                commit_q <= 1'b1;
              end else begin
                state     <= DRAIN;
                drain_cnt <= DRAIN_INIT;
              end
            end
          end
        end
        DRAIN: begin
          if (!stall) begin
            drain_cnt <= drain_cnt - 3'd1;
            if (drain_cnt == 3'd1) begin
              state    <= COMMIT;
              commit_q <= 1'b1;
            end
          end
        end
        COMMIT: begin
          if (!stall) begin
            commit_q <= 1'b0;
            rv_q     <= 1'b1;
            rpc_q    <= is_eret_q ? epc : evec;
            state    <= REDIRECT;
          end
        end
        REDIRECT: begin
          if (redir.redirect_ready) begin
            rv_q    <= 1'b0;
            flush_q <= 1'b0;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // The commit pulse is gated by the live stall so a stalled COMMIT cycle
  // emits nothing; the pulse appears on the first unstalled COMMIT cycle.
  assign trap_commit = commit_q & ~is_eret_q & ~stall;
  assign eret_commit = commit_q & is_eret_q & ~stall;
  assign badvaddr_we = trap_commit & bv_we_q;

  assign flush         = flush_q;
  assign busy          = busy_q;
  assign trap_epc      = epc_q;
  assign trap_cause    = cause_q;
  assign trap_badvaddr = bv_q;
  assign halted        = halted_q;

  assign redir.redirect_valid = rv_q;
  assign redir.redirect_pc    = rpc_q;

endmodule
